morse_encoder: RTL and testbench
================================

# morse_encoder

Character-to-Morse keyer: accepts one ASCII character per valid/ready handshake and drives a single on/off key line with ITU Morse timing. All element and gap durations are integer multiples of one unit of `UNIT_TICKS` clock cycles. It is the transmit-side counterpart of the decoder chain. It feeds the tone/LED output stage, and its key line can loop back into the decoder input for self-test.

## Interface

- `UNIT_TICKS`, default 4, clock cycles per Morse unit (dot length); legal range ≥ 1.
- `clk`  input  1  system clock, rising edge.
- `resetn`  input  1  reset: one clock, reset is synchronous and active-low.
- `char_valid_i`  input  1  upstream character available.
- `char_i`  input  8  ASCII character, sampled only on handshake.
- `char_ready_o`  output  1  encoder can accept a character.
- `key_o`  output  1  key line, 1 = tone on, registered.
- `busy_o`  output  1  equals `!char_ready_o`.
- `err_o`  output  1  one-cycle pulse: accepted character has no Morse code.

## Operation

- Handshake: a transfer occurs on a rising edge where `char_valid_i && char_ready_o`. `char_ready_o` is high only in IDLE and is combinational from state.
- Code table: 'A'–'Z' and '0'–'9' map to standard Morse, 1–5 elements. Internal encoding is length[2:0] plus pattern[4:0], MSB-first, where 1 = dash.
- Space (0x20): no key activity; key held low for 4 units.
  - Combined with the preceding character's 3-unit gap, this gives the 7-unit word gap.
- Any other code is unsupported: accepted and discarded, `err_o` pulsed, no key activity.
- FSM states: IDLE, MARK, ELEM_GAP, CHAR_GAP, WORD_GAP, ERR.
  - IDLE → MARK on handshake with a supported character; loads length, pattern, and the first element duration.
  - IDLE → WORD_GAP on space.
  - IDLE → ERR on an unsupported character.
  - MARK: `key_o`=1 for 1 unit (dot) or 3 units (dash). Then → ELEM_GAP if elements remain, else → CHAR_GAP.
  - ELEM_GAP: `key_o`=0 for 1 unit, then → MARK with the next element (pattern shifted left, remaining count decremented).
  - CHAR_GAP: `key_o`=0 for 3 units, then → IDLE.
  - WORD_GAP: `key_o`=0 for 4 units, then → IDLE.
  - ERR: one cycle, `err_o`=1, then → IDLE.
- Duration counter: down-counter, width `$clog2(4*UNIT_TICKS+1)`.
  - Loaded with duration−1 on state entry; state exits on the cycle the counter reads 0.
  - No wrap-around: the counter is never decremented below 0.
- `char_valid_i` and `char_i` are ignored outside IDLE. Upstream must hold them until the handshake.
- Reset (`resetn`=0 at an edge) from any state:
  - next cycle: IDLE, `key_o`=0, `err_o`=0, `char_ready_o`=1, `busy_o`=0, counter=0, table registers cleared;
  - an in-flight mark is truncated, with no trailing gap.

## Timing

- Reset values: `key_o`=0, `err_o`=0, `char_ready_o`=1, `busy_o`=0.
- Handshake at edge k: `char_ready_o` low and `key_o` (supported character) high from cycle k+1.
- Dot: exactly `UNIT_TICKS` cycles high. Dash: exactly `3*UNIT_TICKS` cycles high. Inter-element gap: exactly `UNIT_TICKS` cycles low.
- After the last element: exactly `3*UNIT_TICKS` low cycles with ready low, then `char_ready_o`=1.
- Total ready-low cycles for a supported character: sum(marks) + (n−1)·U + 3·U, where U = `UNIT_TICKS` and n = element count.
- Space: `4*UNIT_TICKS` ready-low cycles.
- Unsupported character: `err_o` high in cycle k+1 only; `char_ready_o` high again in cycle k+2.
- Back-to-back: if `char_valid_i` is high when ready reasserts, the next handshake occurs that same cycle. There are no bubble cycles beyond the gaps.
- `UNIT_TICKS`=1 is legal: a dot is a single high cycle.

## Configuration

- `MORSE_ENC_LOWERCASE_EN` defined: 'a'–'z' (0x61–0x7A) fold to 'A'–'Z' before lookup and encode identically.
- Not defined: lowercase is unsupported (ERR path, `err_o` pulse). No fold logic is compiled.

## Test plan

- UNIT_TICKS=4, send 'E' → `key_o` high 4 cycles starting the cycle after handshake, low 12 cycles, then `char_ready_o`=1; ready low for 16 cycles total.
- Send 'A' → key high 4, low 4, high 12, low 12; ready low for 32 cycles. Send '0' → five 12-cycle marks separated by 4-cycle gaps, then 12 low; ready low for 88 cycles.
- Stream "T T" with valid held high → key high 12, low 12, low 16 (space), high 12, low 12. No extra idle cycles between characters.
- Send '#' → `err_o`=1 for exactly one cycle, `key_o` stays 0, ready high again 2 cycles after handshake. Send 'e' → with macro, same waveform as 'E'; without macro, `err_o` pulse.
- Assert `resetn`=0 for one cycle mid-dash of 'T' → next cycle `key_o`=0, `char_ready_o`=1, `err_o`=0. A following 'E' encodes normally.
- UNIT_TICKS=1, send 'S' → key pattern 1,0,1,0,1 then 3 low cycles; ready low for 8 cycles.

Source files
------------

// File: rtl/morse_encoder.sv
// ASCII-to-Morse keyer: one character per valid/ready handshake, ITU timing in units of UNIT_TICKS cycles.
// Optional feature macro: MORSE_ENC_LOWERCASE_EN (fold 'a'-'z' onto 'A'-'Z' before lookup).
module morse_encoder #(
    parameter int UNIT_TICKS = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       char_valid_i,
    input  logic [7:0] char_i,
    output logic       char_ready_o,
    output logic       key_o,
    output logic       busy_o,
    output logic       err_o
);

    localparam int CNT_W = $clog2(4 * UNIT_TICKS + 1);
    localparam logic [CNT_W-1:0] DUR_1U = CNT_W'(UNIT_TICKS - 1);
    localparam logic [CNT_W-1:0] DUR_3U = CNT_W'(3 * UNIT_TICKS - 1);
    localparam logic [CNT_W-1:0] DUR_4U = CNT_W'(4 * UNIT_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        MARK,
        ELEM_GAP,
        CHAR_GAP,
        WORD_GAP,
        ERR
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_len;
    logic [4:0]       r_pat;
    logic             r_key;
    logic             r_err;

    state_t           w_state_n;
    logic [CNT_W-1:0] w_cnt_n;
    logic [2:0]       w_len_n;
    logic [4:0]       w_pat_n;
    logic [7:0]       w_char;
    logic [7:0]       w_code;
    logic [2:0]       w_len;
    logic [4:0]       w_pat;

    // {length, pattern}: pattern is left-aligned, bit 4 is the first element, 1 = dash; length 0 = unsupported
    function automatic logic [7:0] lookup(input logic [7:0] c);
        case (c)
            8'h41: return {3'd2, 5'b01000};  // A
            8'h42: return {3'd4, 5'b10000};  // B
            8'h43: return {3'd4, 5'b10100};  // C
            8'h44: return {3'd3, 5'b10000};  // D
            8'h45: return {3'd1, 5'b00000};  // E
            8'h46: return {3'd4, 5'b00100};  // F
            8'h47: return {3'd3, 5'b11000};  // G
            8'h48: return {3'd4, 5'b00000};  // H
            8'h49: return {3'd2, 5'b00000};  // I
            8'h4A: return {3'd4, 5'b01110};  // J
            8'h4B: return {3'd3, 5'b10100};  // K
            8'h4C: return {3'd4, 5'b01000};  // L
            8'h4D: return {3'd2, 5'b11000};  // M
            8'h4E: return {3'd2, 5'b10000};  // N
            8'h4F: return {3'd3, 5'b11100};  // O
            8'h50: return {3'd4, 5'b01100};  // P
            8'h51: return {3'd4, 5'b11010};  // Q
            8'h52: return {3'd3, 5'b01000};  // R
            8'h53: return {3'd3, 5'b00000};  // S
            8'h54: return {3'd1, 5'b10000};  // T
            8'h55: return {3'd3, 5'b00100};  // U
            8'h56: return {3'd4, 5'b00010};  // V
            8'h57: return {3'd3, 5'b01100};  // W
            8'h58: return {3'd4, 5'b10010};  // X
            8'h59: return {3'd4, 5'b10110};  // Y
            8'h5A: return {3'd4, 5'b11000};  // Z
            8'h30: return {3'd5, 5'b11111};  // 0
            8'h31: return {3'd5, 5'b01111};  // 1
            8'h32: return {3'd5, 5'b00111};  // 2
            8'h33: return {3'd5, 5'b00011};  // 3
            8'h34: return {3'd5, 5'b00001};  // 4
            8'h35: return {3'd5, 5'b00000};  // 5
            8'h36: return {3'd5, 5'b10000};  // 6
            8'h37: return {3'd5, 5'b11000};  // 7
            8'h38: return {3'd5, 5'b11100};  // 8
            8'h39: return {3'd5, 5'b11110};  // 9
            default: return 8'h00;
        endcase
    endfunction

`ifdef MORSE_ENC_LOWERCASE_EN
    always_comb begin
        w_char = char_i;
        if (char_i >= 8'h61 && char_i <= 8'h7A) begin
            w_char = char_i - 8'h20;
        end
    end
`else
    assign w_char = char_i;
`endif

    assign w_code = lookup(w_char);
    assign w_len  = w_code[7:5];
    assign w_pat  = w_code[4:0];

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = (r_cnt != '0) ? r_cnt - CNT_W'(1) : '0;
        w_len_n   = r_len;
        w_pat_n   = r_pat;
        case (r_state)
            IDLE: begin
                if (char_valid_i) begin
                    if (w_char == 8'h20) begin
                        w_state_n = WORD_GAP;
                        w_cnt_n   = DUR_4U;
                    end else if (w_len != 3'd0) begin
                        w_state_n = MARK;
                        w_len_n   = w_len;
                        w_pat_n   = w_pat;
                        w_cnt_n   = w_pat[4] ? DUR_3U : DUR_1U;
                    end else begin
                        w_state_n = ERR;
                        w_cnt_n   = '0;
                    end
                end
            end
            MARK: begin
                if (r_cnt == '0) begin
                    if (r_len > 3'd1) begin
                        w_state_n = ELEM_GAP;
                        w_cnt_n   = DUR_1U;
                    end else begin
                        w_state_n = CHAR_GAP;
                        w_cnt_n   = DUR_3U;
                    end
                end
            end
            ELEM_GAP: begin
                // r_pat[3] is the element that becomes current after the shift
                if (r_cnt == '0) begin
                    w_state_n = MARK;
                    w_len_n   = r_len - 3'd1;
                    w_pat_n   = {r_pat[3:0], 1'b0};
                    w_cnt_n   = r_pat[3] ? DUR_3U : DUR_1U;
                end
            end
            CHAR_GAP, WORD_GAP: begin
                if (r_cnt == '0) begin
                    w_state_n = IDLE;
                end
            end
            ERR: begin
                w_state_n = IDLE;
            end
            default: begin
                w_state_n = IDLE;
                w_cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_len   <= '0;
            r_pat   <= '0;
            r_key   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_len   <= w_len_n;
            r_pat   <= w_pat_n;
            r_key   <= (w_state_n == MARK);
            r_err   <= (w_state_n == ERR);
        end
    end

    assign char_ready_o = (r_state == IDLE);
    assign busy_o       = (r_state != IDLE);
    assign key_o        = r_key;
    assign err_o        = r_err;

endmodule

// File: tb/tb_morse_encoder.sv
// Scoreboard bench for morse_encoder: stimulus pushes expected busy episodes, per-DUT monitors pop and compare.
module tb_morse_encoder;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn;
    logic       v4, v1;
    logic [7:0] c4, c1;
    logic       rdy4, key4, busy4, err4;
    logic       rdy1, key1, busy1, err1;

    morse_encoder #(.UNIT_TICKS(4)) u_dut4 (
        .clk(clk), .resetn(resetn), .char_valid_i(v4), .char_i(c4),
        .char_ready_o(rdy4), .key_o(key4), .busy_o(busy4), .err_o(err4)
    );

    morse_encoder #(.UNIT_TICKS(1)) u_dut1 (
        .clk(clk), .resetn(resetn), .char_valid_i(v1), .char_i(c1),
        .char_ready_o(rdy1), .key_o(key1), .busy_o(busy1), .err_o(err1)
    );

    typedef struct {
        string        name;
        int           blen;
        logic [255:0] wave;
        int           errs;
        int           idle_before;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Expected key waveform from a Morse string ('.'/'-'), unit u; busy length is given by hand
    function automatic exp_t mk(input string name, input string code, input int u,
                                input int blen, input int errs, input int idle_before);
        exp_t e;
        int   pos;
        e.name        = name;
        e.blen        = blen;
        e.errs        = errs;
        e.idle_before = idle_before;
        e.wave        = '0;
        pos           = 0;
        for (int i = 0; i < code.len(); i++) begin
            int len;
            if (i > 0) pos += u;
            len = (code[i] == "-") ? 3 * u : u;
            for (int j = 0; j < len; j++) begin
                if (pos + j < 256) e.wave[pos+j] = 1'b1;
            end
            pos += len;
        end
        return e;
    endfunction

    task automatic finish_ep(input int idx, input int blen, input logic [255:0] wave,
                             input int errs, input int idle);
        exp_t e;
        int   first_bad;
        if ((idx == 0 && q4.size() == 0) || (idx == 1 && q1.size() == 0)) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_episode_dut%0d: got busy %0d cycles, required none", idx, blen);
            return;
        end
        if (idx == 0) e = q4.pop_front();
        else          e = q1.pop_front();
        chk({e.name, "_busy_len"}, blen, e.blen);
        chk({e.name, "_err_pulses"}, errs, e.errs);
        if (e.idle_before >= 0) chk({e.name, "_idle_before"}, idle, e.idle_before);
        first_bad = -1;
        for (int i = 0; i < blen && i < e.blen && i < 256; i++) begin
            if (first_bad < 0 && wave[i] !== e.wave[i]) first_bad = i;
        end
        n_checks++;
        if (first_bad >= 0) begin
            n_fail++;
            $display("FAIL %s_key_wave: busy cycle %0d got key=%0b required %0b",
                     e.name, first_bad, wave[first_bad], e.wave[first_bad]);
        end
    endtask

    int           bc4 = 0, ec4 = 0, idl4 = 0, isv4 = 0;
    logic [255:0] w4;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy_vs_ready_u4", int'(busy4), int'(!rdy4));
            if (busy4) begin
                if (bc4 == 0) begin
                    isv4 = idl4;
                    w4   = '0;
                    ec4  = 0;
                end
                if (bc4 < 256) w4[bc4] = key4;
                ec4 += int'(err4);
                bc4++;
            end else begin
                if (bc4 > 0) begin
                    finish_ep(0, bc4, w4, ec4, isv4);
                    bc4  = 0;
                    idl4 = 0;
                end
                chk("idle_key_u4", int'(key4), 0);
                chk("idle_err_u4", int'(err4), 0);
                idl4++;
            end
        end
    end

    int           bc1 = 0, ec1 = 0, idl1 = 0, isv1 = 0;
    logic [255:0] w1;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy_vs_ready_u1", int'(busy1), int'(!rdy1));
            if (busy1) begin
                if (bc1 == 0) begin
                    isv1 = idl1;
                    w1   = '0;
                    ec1  = 0;
                end
                if (bc1 < 256) w1[bc1] = key1;
                ec1 += int'(err1);
                bc1++;
            end else begin
                if (bc1 > 0) begin
                    finish_ep(1, bc1, w1, ec1, isv1);
                    bc1  = 0;
                    idl1 = 0;
                end
                chk("idle_key_u1", int'(key1), 0);
                chk("idle_err_u1", int'(err1), 0);
                idl1++;
            end
        end
    end

    // Present c, wait (bounded) for ready, handshake on the next edge; returns #1 after that edge
    task automatic send(input int idx, input logic [7:0] c, input bit hold);
        int t;
        t = 0;
        if (idx == 0) begin c4 = c; v4 = 1'b1; end
        else          begin c1 = c; v1 = 1'b1; end
        while (!(idx == 0 ? rdy4 : rdy1) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) begin
            chk("ready_timeout", 0, 1);
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            if (idx == 0) v4 = 1'b0;
            else          v1 = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((q4.size() > 0 || q1.size() > 0) && t < 2000) begin
            @(negedge clk);
            t++;
        end
    endtask

    initial begin
        resetn = 1'b0;
        v4 = 1'b0; v1 = 1'b0; c4 = 8'h00; c1 = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_key", int'(key4), 0);
        chk("reset_err", int'(err4), 0);
        chk("reset_ready", int'(rdy4), 1);
        chk("reset_busy", int'(busy4), 0);
        chk("reset_ready_u1", int'(rdy1), 1);
        resetn = 1'b1;
        mon_en = 1'b1;

        // UNIT_TICKS=1: dot is a single cycle
        q1.push_back(mk("S_u1", "...", 1, 8, 0, -1));
        send(1, "S", 1'b0);
        q1.push_back(mk("E_u1", ".", 1, 4, 0, -1));
        send(1, "E", 1'b0);
        wait_drain();

        q4.push_back(mk("E", ".", 4, 16, 0, -1));
        send(0, "E", 1'b0);
        q4.push_back(mk("A", ".-", 4, 32, 0, -1));
        send(0, "A", 1'b0);
        q4.push_back(mk("zero", "-----", 4, 88, 0, -1));
        send(0, "0", 1'b0);

        // "T T" streamed with valid held: exactly one ready cycle between characters
        q4.push_back(mk("T1", "-", 4, 24, 0, -1));
        q4.push_back(mk("space", "", 4, 16, 0, 1));
        q4.push_back(mk("T2", "-", 4, 24, 0, 1));
        send(0, "T", 1'b1);
        send(0, " ", 1'b1);
        send(0, "T", 1'b0);

        q4.push_back(mk("hash", "", 4, 1, 1, -1));
        send(0, "#", 1'b0);
`ifdef MORSE_ENC_LOWERCASE_EN
        q4.push_back(mk("e_lower", ".", 4, 16, 0, -1));
`else
        q4.push_back(mk("e_lower", "", 4, 1, 1, -1));
`endif
        send(0, "e", 1'b0);
        wait_drain();

        // Reset during the dash of 'T': five high cycles then truncation
        q4.push_back(mk("T_rst", "-", 4, 5, 0, -1));
        send(0, "T", 1'b0);
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("midreset_key", int'(key4), 0);
        chk("midreset_ready", int'(rdy4), 1);
        chk("midreset_err", int'(err4), 0);
        resetn = 1'b1;

        q4.push_back(mk("E_after_rst", ".", 4, 16, 0, -1));
        send(0, "E", 1'b0);
        wait_drain();
        repeat (2) @(negedge clk);
        chk("pending_expectations", q4.size() + q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
